// File: rtl/seq_alu_pkg.sv
// Purpose: shared opcode mnemonics, sequencer states and decode helpers for seq_alu.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package seq_alu_pkg;

   // Opcode field width; the op_mne encoding must fit in it.
   localparam int OP_W = 5;

   // Legacy opcodes 0-13 keep their historic encodings; 14-18 were added with the sequencer.
   typedef enum logic [OP_W-1:0] {
      LK   = 5'd0,
      LOAD = 5'd1,
      ADD  = 5'd2,
      SUB  = 5'd3,
      MOV  = 5'd4,
      LW   = 5'd5,
      SW   = 5'd6,
      SL   = 5'd7,
      SR   = 5'd8,
      AND  = 5'd9,
      XOR  = 5'd10,
      EQ   = 5'd11,
      LT   = 5'd12,
      GT   = 5'd13,
      ADC  = 5'd14,
      SBC  = 5'd15,
      SLN  = 5'd16,
      SRN  = 5'd17,
      MUL  = 5'd18
   } op_mne;

   // Sequencer states: idle, iterating (Busy), result-just-written (Done).
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } alu_state_e;

   // Encoding used for opcodes whose upper bits fall outside op_mne; decodes as undefined.
   localparam logic [OP_W-1:0] OP_UNDEF = 5'h1F;

   // Multi-bit shifts iterate one bit per cycle when the shift count is non-zero.
   function automatic logic is_shift_op(input logic [OP_W-1:0] op);
      return (op == SLN) || (op == SRN);
   endfunction

endpackage

// File: rtl/alu_core.sv
// Purpose: single-cycle datapath returning {carry, result} for every non-iterative operation.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the result is captured.
module alu_core
   import seq_alu_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [OP_W-1:0] op,
   input  logic            mode,
   input  logic [W-1:0]    a,
   input  logic [W-1:0]    b,
   input  logic            c_in,
   output logic [W-1:0]    result,
   output logic            c_out
);

   // W+1 bit adder shared by ADD/SUB/ADC/SBC; bit W is the carry (or not-borrow).
   logic [W:0] sum;

   // Opcode decode; carry defaults to the incoming flag so untouched ops preserve it.
   always_comb begin
      result = '0;
      c_out  = c_in;
      sum    = '0;
      if (mode) begin
         // Branch-on-zero: hand back the target only when the accumulator is zero.
         result = (a == '0) ? b : '0;
      end else begin
         case (op)
            LK, LOAD, MOV, LW, SW: result = b;
            ADD: begin
               sum    = {1'b0, a} + {1'b0, b};
               result = sum[W-1:0];
               c_out  = sum[W];
            end
            SUB: begin
               // a + ~b + 1: carry out set means no borrow.
               sum    = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
               result = sum[W-1:0];
               c_out  = sum[W];
            end
            ADC: begin
               sum    = {1'b0, a} + {1'b0, b} + (W+1)'(c_in);
               result = sum[W-1:0];
               c_out  = sum[W];
            end
            SBC: begin
               // a - b - ~c == a + ~b + c, so the incoming carry doubles as not-borrow.
               sum    = {1'b0, a} + {1'b0, ~b} + (W+1)'(c_in);
               result = sum[W-1:0];
               c_out  = sum[W];
            end
            SL:  result = {a[W-2:0], 1'b0};
            SR:  result = {1'b0, a[W-1:1]};
            AND: result = a & b;
            XOR: result = a ^ b;
            EQ:  result = {{(W-1){1'b0}}, (a == b)};
            LT:  result = {{(W-1){1'b0}}, (a < b)};
            GT:  result = {{(W-1){1'b0}}, (a > b)};
            // Only reached with a zero shift count: value passes through, carry kept.
            SLN, SRN: result = a;
            default: result = '0;
         endcase
      end
   end

endmodule

// File: rtl/seq_alu.sv
// Purpose: clocked accumulator ALU with registered result/flags, carry chaining, iterative shift and multiply.
// Latency: Done 1 cycle after Start for single-cycle ops, n+1 for shifts by n, W+1 for MUL.
// Backpressure: Start is ignored while Busy; Start during the Done cycle is accepted back-to-back.
module seq_alu #(
   parameter int W   = 8,
   parameter int Ops = 5,
   parameter int SW  = $clog2(W)
) (
   input  logic           Clk,
   input  logic           Reset_n,
   input  logic           Start,
   input  logic [Ops-1:0] OP,
   input  logic           Mode,
   input  logic [W-1:0]   R0,
   input  logic [W-1:0]   Input,
   output logic           Busy,
   output logic           Done,
   output logic [W-1:0]   Out,
   output logic [W-1:0]   Out_hi,
   output logic           C_out,
   output logic           Zero,
   output logic           Neg
);

   import seq_alu_pkg::*;

   // Counter must reach W for MUL.
   localparam int CW = $clog2(W + 1);

   alu_state_e      state_q;
   logic [OP_W-1:0] op_dec;
   logic [OP_W-1:0] op_q;
   logic [CW-1:0]   cnt_q;
   logic [W-1:0]    work_lo_q;
   logic [W-1:0]    work_hi_q;
   logic [W-1:0]    mcand_q;
   logic [W-1:0]    out_q;
   logic [W-1:0]    out_hi_q;
   logic            c_q;
   logic            zero_q;
   logic            neg_q;

   logic [W-1:0]    core_res;
   logic            core_c;
   logic [W-1:0]    step_lo;
   logic [W-1:0]    step_hi;
   logic            step_c;
   logic [W:0]      mul_sum;

   logic [SW-1:0]   amt;
   logic            accept;
   logic            is_mul;
   logic            go_iter;
   logic            launch_iter;
   logic            launch_single;
   logic            finish_iter;

   // Opcodes wider than op_mne decode as undefined when any extra bit is set.
   generate
      if (Ops > OP_W) begin : g_op_wide
         assign op_dec = (|OP[Ops-1:OP_W]) ? OP_UNDEF : OP[OP_W-1:0];
      end else begin : g_op_exact
         assign op_dec = OP[OP_W-1:0];
      end
   endgenerate

   assign amt           = Input[SW-1:0];
   assign accept        = Start && (state_q != RUN);
   assign is_mul        = !Mode && (op_dec == MUL);
   assign go_iter       = is_mul || (!Mode && is_shift_op(op_dec) && (amt != '0));
   assign launch_iter   = accept && go_iter;
   assign launch_single = accept && !go_iter;
   assign finish_iter   = (state_q == RUN) && (cnt_q == CW'(1));

   alu_core #(
      .W (W)
   ) u_core (
      .op     (op_dec),
      .mode   (Mode),
      .a      (R0),
      .b      (Input),
      .c_in   (c_q),
      .result (core_res),
      .c_out  (core_c)
   );

   // One iteration step: single-bit shift, or shift-add multiply on the {hi, lo} pair.
   always_comb begin
      step_lo = work_lo_q;
      step_hi = work_hi_q;
      step_c  = c_q;
      mul_sum = '0;
      case (op_q)
         SLN: begin
            step_c  = work_lo_q[W-1];
            step_lo = {work_lo_q[W-2:0], 1'b0};
         end
         SRN: begin
            step_c  = work_lo_q[0];
            step_lo = {1'b0, work_lo_q[W-1:1]};
         end
         MUL: begin
            // lo holds the unconsumed multiplier bits; product bits shift in from the top.
            mul_sum = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, mcand_q} : {(W+1){1'b0}});
            {step_hi, step_lo} = {mul_sum, work_lo_q[W-1:1]};
         end
         default: ;
      endcase
   end

   // Sequencer: IDLE/FIN accept a new op, RUN counts down to FIN.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= IDLE;
      end else begin
         case (state_q)
            IDLE, FIN: begin
               if (!Start)       state_q <= IDLE;
               else if (go_iter) state_q <= RUN;
               else              state_q <= FIN;
            end
            RUN: begin
               if (finish_iter) state_q <= FIN;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Operand capture at launch and working-register update while iterating.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         op_q      <= '0;
         cnt_q     <= '0;
         work_lo_q <= '0;
         work_hi_q <= '0;
         mcand_q   <= '0;
      end else if (launch_iter) begin
         op_q      <= op_dec;
         cnt_q     <= is_mul ? CW'(W) : CW'(amt);
         work_lo_q <= is_mul ? Input : R0;
         work_hi_q <= '0;
         mcand_q   <= R0;
      end else if (state_q == RUN) begin
         cnt_q     <= cnt_q - CW'(1);
         work_lo_q <= step_lo;
         work_hi_q <= step_hi;
      end
   end

   // Architectural result and flags change only on the edge that enters FIN.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         out_q    <= '0;
         out_hi_q <= '0;
         c_q      <= 1'b0;
         zero_q   <= 1'b1;
         neg_q    <= 1'b0;
      end else if (launch_single) begin
         out_q    <= core_res;
         out_hi_q <= '0;
         c_q      <= core_c;
         zero_q   <= (core_res == '0);
         neg_q    <= core_res[W-1];
      end else if (finish_iter) begin
         out_q    <= step_lo;
         out_hi_q <= step_hi;
         c_q      <= step_c;
         zero_q   <= ({step_hi, step_lo} == '0);
         neg_q    <= step_lo[W-1];
      end
   end

   assign Busy   = (state_q == RUN);
   assign Done   = (state_q == FIN);
   assign Out    = out_q;
   assign Out_hi = out_hi_q;
   assign C_out  = c_q;
   assign Zero   = zero_q;
   assign Neg    = neg_q;

`ifdef __ICARUS__
   // Mnemonic view of the in-flight iterative opcode for waveform viewers.
   op_mne op_disp;
   assign op_disp = op_mne'(op_q);
`endif

endmodule

// File: tb/tb_seq_alu.sv
// Purpose: self-checking bench for seq_alu (W=8) with a result scoreboard and timing checks.
// Latency: checks Done latency and Busy length per operation class.
// Backpressure: exercises Start-while-Busy rejection and back-to-back Start in FIN.
module tb_seq_alu;

   localparam int W = 8;

   localparam int OP_LK  = 0;
   localparam int OP_ADD = 2;
   localparam int OP_SUB = 3;
   localparam int OP_MOV = 4;
   localparam int OP_SL  = 7;
   localparam int OP_SR  = 8;
   localparam int OP_AND = 9;
   localparam int OP_XOR = 10;
   localparam int OP_EQ  = 11;
   localparam int OP_LT  = 12;
   localparam int OP_GT  = 13;
   localparam int OP_ADC = 14;
   localparam int OP_SBC = 15;
   localparam int OP_SLN = 16;
   localparam int OP_SRN = 17;
   localparam int OP_MUL = 18;

   typedef struct {
      logic [7:0] res;
      logic [7:0] hi;
      logic       c;
      logic       z;
      logic       n;
      int         lat;
   } exp_t;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [4:0]   op_i;
   logic         mode;
   logic [W-1:0] r0_i;
   logic [W-1:0] in_i;
   logic         busy;
   logic         done;
   logic [W-1:0] out;
   logic [W-1:0] out_hi;
   logic         c_out;
   logic         zero;
   logic         neg;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   logic mc       = 1'b0;

   seq_alu #(
      .W   (W),
      .Ops (5)
   ) dut (
      .Clk     (clk),
      .Reset_n (rst_n),
      .Start   (start),
      .OP      (op_i),
      .Mode    (mode),
      .R0      (r0_i),
      .Input   (in_i),
      .Busy    (busy),
      .Done    (done),
      .Out     (out),
      .Out_hi  (out_hi),
      .C_out   (c_out),
      .Zero    (zero),
      .Neg     (neg)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model with plain integer arithmetic.
   function automatic exp_t model(input int op, input bit md, input int a, input int b, input logic c);
      exp_t e;
      int   r;
      int   n;
      logic nc;
      nc    = c;
      n     = b % 8;
      r     = 0;
      e.hi  = 8'h00;
      e.lat = 1;
      if (md) begin
         r = (a == 0) ? b : 0;
      end else begin
         case (op)
            0, 1, 4, 5, 6: r = b;
            OP_ADD: begin r = a + b; nc = (r > 255); end
            OP_SUB: begin r = a - b; nc = (r >= 0); end
            OP_SL:  r = a * 2;
            OP_SR:  r = a / 2;
            OP_AND: r = a & b;
            OP_XOR: r = a ^ b;
            OP_EQ:  r = (a == b) ? 1 : 0;
            OP_LT:  r = (a < b) ? 1 : 0;
            OP_GT:  r = (a > b) ? 1 : 0;
            OP_ADC: begin r = a + b + (c ? 1 : 0); nc = (r > 255); end
            OP_SBC: begin r = a - b - (c ? 0 : 1); nc = (r >= 0); end
            OP_SLN: begin
               r = a << n;
               if (n > 0) nc = ((a >> (8 - n)) & 1) != 0;
               e.lat = n + 1;
            end
            OP_SRN: begin
               r = a >> n;
               if (n > 0) nc = ((a >> (n - 1)) & 1) != 0;
               e.lat = n + 1;
            end
            OP_MUL: begin
               r     = a * b;
               e.hi  = r[15:8];
               e.lat = 9;
            end
            default: r = 0;
         endcase
      end
      e.res = r[7:0];
      e.z   = (e.res == 8'h00) && (e.hi == 8'h00);
      e.n   = e.res[7];
      e.c   = nc;
      return e;
   endfunction

   // Scoreboard: every Done pops one expectation and compares the architectural outputs.
   always @(negedge clk) begin : scoreboard
      exp_t e;
      if (rst_n === 1'b1 && done === 1'b1) begin
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_done: Done=1 with nothing outstanding, Out=%h", out);
         end else begin
            e = sb.pop_front();
            if (out !== e.res || out_hi !== e.hi || c_out !== e.c || zero !== e.z || neg !== e.n) begin
               n_fail++;
               $display("FAIL result: got Out=%h Out_hi=%h C=%b Z=%b N=%b, want Out=%h Out_hi=%h C=%b Z=%b N=%b",
                        out, out_hi, c_out, zero, neg, e.res, e.hi, e.c, e.z, e.n);
            end
         end
      end
   end

   // Called at a falling edge: drives Start with operands, records the expectation, returns after the sampling edge.
   task automatic issue(input int op, input bit md, input int a, input int b);
      exp_t e;
      e = model(op, md, a, b, mc);
      mc = e.c;
      sb.push_back(e);
      start = 1'b1;
      op_i  = op[4:0];
      mode  = md;
      r0_i  = a[7:0];
      in_i  = b[7:0];
      @(posedge clk);
   endtask

   // Drops Start and counts falling edges until Done, bounded by maxc.
   task automatic wait_done(input int maxc, output int lat, output int bn);
      lat = 0;
      bn  = 0;
      do begin
         @(negedge clk);
         start = 1'b0;
         lat++;
         if (busy === 1'b1) bn++;
      end while (done !== 1'b1 && lat < maxc);
      if (done !== 1'b1) begin
         n_checks++;
         n_fail++;
         $display("FAIL done_timeout: no Done within %0d cycles", maxc);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      op_i  = '0;
      mode  = 1'b0;
      r0_i  = '0;
      in_i  = '0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (out !== 8'h00 || out_hi !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_data: got Out=%h Out_hi=%h, want 00 00", out, out_hi);
      end
      n_checks++;
      if (c_out !== 1'b0 || zero !== 1'b1 || neg !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got C=%b Z=%b N=%b, want C=0 Z=1 N=0", c_out, zero, neg);
      end
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_handshake: got Busy=%b Done=%b, want 0 0", busy, done);
      end
      rst_n = 1'b1;
      mc    = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_add_adc();
      int lat;
      int bn;
      issue(OP_ADD, 1'b0, 'hF0, 'h20);
      wait_done(10, lat, bn);
      n_checks++;
      if (lat !== 1) begin
         n_fail++;
         $display("FAIL add_latency: got %0d cycles, want 1", lat);
      end
      issue(OP_ADC, 1'b0, 'h01, 'h01);
      wait_done(10, lat, bn);
      n_checks++;
      if (lat !== 1) begin
         n_fail++;
         $display("FAIL adc_latency: got %0d cycles, want 1", lat);
      end
   endtask

   task automatic test_mul();
      int lat;
      int bn;
      issue(OP_MUL, 1'b0, 'h0D, 'h0B);
      wait_done(20, lat, bn);
      n_checks++;
      if (lat !== 9 || bn !== 8) begin
         n_fail++;
         $display("FAIL mul_timing: got Done at %0d, Busy %0d cycles, want 9 and 8", lat, bn);
      end
      issue(OP_MUL, 1'b0, 'hFF, 'hFF);
      wait_done(20, lat, bn);
      n_checks++;
      if (lat !== 9) begin
         n_fail++;
         $display("FAIL mul_ff_latency: got %0d cycles, want 9", lat);
      end
   endtask

   task automatic test_shift();
      int lat;
      int bn;
      issue(OP_SLN, 1'b0, 'h81, 'h03);
      wait_done(20, lat, bn);
      n_checks++;
      if (lat !== 4 || bn !== 3) begin
         n_fail++;
         $display("FAIL sln3_timing: got Done at %0d, Busy %0d cycles, want 4 and 3", lat, bn);
      end
      issue(OP_SRN, 1'b0, 'h81, 'h01);
      wait_done(20, lat, bn);
      n_checks++;
      if (lat !== 2) begin
         n_fail++;
         $display("FAIL srn1_latency: got %0d cycles, want 2", lat);
      end
      issue(OP_SLN, 1'b0, 'h81, 'h00);
      wait_done(20, lat, bn);
      n_checks++;
      if (lat !== 1 || bn !== 0) begin
         n_fail++;
         $display("FAIL sln0_timing: got Done at %0d, Busy %0d cycles, want 1 and 0", lat, bn);
      end
   endtask

   task automatic test_legacy();
      int ops [12] = '{OP_SUB, OP_AND, OP_XOR, OP_EQ, OP_LT, OP_GT, OP_SL, OP_SR, OP_SBC, OP_LK, OP_MOV, 20};
      int as  [12] = '{'h05, 'hF0, 'hF0, 'h33, 'h02, 'h02, 'h81, 'h81, 'h10, 'h00, 'h77, 'h55};
      int bs  [12] = '{'h07, 'h3C, 'h3C, 'h33, 'h03, 'h03, 'h00, 'h00, 'h01, 'h5A, 'h00, 'h66};
      int lat;
      int bn;
      for (int i = 0; i < 12; i++) begin
         issue(ops[i], 1'b0, as[i], bs[i]);
         wait_done(10, lat, bn);
         n_checks++;
         if (lat !== 1) begin
            n_fail++;
            $display("FAIL legacy_latency: op %0d got %0d cycles, want 1", ops[i], lat);
         end
      end
   endtask

   task automatic test_branch();
      int lat;
      int bn;
      issue(OP_ADD, 1'b0, 'hF0, 'h20);
      wait_done(10, lat, bn);
      issue(OP_ADD, 1'b1, 'h00, 'h2A);
      wait_done(10, lat, bn);
      n_checks++;
      if (lat !== 1) begin
         n_fail++;
         $display("FAIL branch_taken_latency: got %0d cycles, want 1", lat);
      end
      issue(OP_MUL, 1'b1, 'h05, 'h2A);
      wait_done(10, lat, bn);
      n_checks++;
      if (lat !== 1 || bn !== 0) begin
         n_fail++;
         $display("FAIL branch_not_taken_timing: got Done at %0d, Busy %0d cycles, want 1 and 0", lat, bn);
      end
   endtask

   task automatic test_start_while_busy();
      int lat;
      int l2;
      int bn;
      int extra;
      issue(OP_MUL, 1'b0, 'h0D, 'h0B);
      lat = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         start = 1'b0;
         lat++;
      end
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL busy_mid_mul: got Busy=%b, want 1", busy);
      end
      start = 1'b1;
      op_i  = OP_SUB;
      r0_i  = 8'h55;
      in_i  = 8'h11;
      wait_done(20, l2, bn);
      n_checks++;
      if (lat + l2 !== 9) begin
         n_fail++;
         $display("FAIL ignored_start_latency: got Done at %0d, want 9", lat + l2);
      end
      extra = 0;
      repeat (3) begin
         @(negedge clk);
         if (done === 1'b1) extra++;
      end
      n_checks++;
      if (extra !== 0) begin
         n_fail++;
         $display("FAIL ignored_start_extra_done: got %0d extra Done cycles, want 0", extra);
      end
   endtask

   task automatic test_back_to_back();
      logic d1;
      logic d2;
      logic d3;
      issue(OP_ADD, 1'b0, 'h03, 'h04);
      @(negedge clk);
      d1 = done;
      issue(OP_XOR, 1'b0, 'h0F, 'hF0);
      @(negedge clk);
      start = 1'b0;
      d2 = done;
      @(negedge clk);
      d3 = done;
      n_checks++;
      if (d1 !== 1'b1 || d2 !== 1'b1 || d3 !== 1'b0) begin
         n_fail++;
         $display("FAIL back_to_back_done: got %b%b%b, want 110", d1, d2, d3);
      end
   endtask

   task automatic test_reset_abort();
      int bad;
      issue(OP_MUL, 1'b0, 'h0D, 'h0B);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         start = 1'b0;
      end
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_precondition_busy: got Busy=%b, want 1", busy);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (out !== 8'h00 || out_hi !== 8'h00 || c_out !== 1'b0 || zero !== 1'b1 || neg !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_outputs: got Out=%h Out_hi=%h C=%b Z=%b N=%b, want 00 00 0 1 0",
                  out, out_hi, c_out, zero, neg);
      end
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_handshake: got Busy=%b Done=%b, want 0 0", busy, done);
      end
      sb.delete();
      mc = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      repeat (12) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) bad++;
      end
      n_checks++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL abort_idle: got %0d cycles with Busy or Done after release, want 0", bad);
      end
   endtask

   initial begin
      test_reset();
      test_add_adc();
      test_mul();
      test_shift();
      test_legacy();
      test_branch();
      test_start_while_busy();
      test_back_to_back();
      test_reset_abort();
      n_checks++;
      if (sb.size() !== 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d results outstanding, want 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
